// File: rtl/decode_group_queue.sv
// Decode-stage front buffer: compacts fetch lanes, tags delay slots, squashes
// lanes behind a false jump prediction and queues the surviving groups.
module decode_group_queue #(
  parameter int LANES = 2,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                flush,
  input  logic [LANES-1:0]    in_valid,
  input  logic [31:0]         in_pc,
  input  logic [LANES-1:0]    in_is_branch,
  input  logic [LANES-1:0]    in_is_likely,
  input  logic [LANES-1:0]    in_bp_taken,
  input  logic                in_exc,
  output logic                in_ready,
  output logic [LANES-1:0]    out_valid,
  output logic [32*LANES-1:0] out_pc,
  output logic [LANES-1:0]    out_in_ds,
  output logic [LANES-1:0]    out_likely_ds,
  output logic [LANES-1:0]    out_exc,
  input  logic                out_ready,
  output logic                redirect_valid,
  output logic [31:0]         redirect_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          pend_q, pend_d, pend_likely_q, pend_likely_d;
  logic [31:0]   pend_pc_q, pend_pc_d;
  logic          redirect_valid_q, redirect_valid_d;
  logic [31:0]   redirect_pc_q, redirect_pc_d;

  logic [LANES-1:0]    mem_valid_q [DEPTH];
  logic [LANES-1:0]    mem_ds_q    [DEPTH];
  logic [LANES-1:0]    mem_lk_q    [DEPTH];
  logic [LANES-1:0]    mem_exc_q   [DEPTH];
  logic [32*LANES-1:0] mem_pc_q    [DEPTH];

  logic             acc, push, pop;
  logic [LANES-1:0] keep;
  logic             offend;
  logic [31:0]      off_pc;

  // The first offender is kept; every lane above it is on the wrong path.
  // NOTE: always_comb uses blocking '=' so later loop iterations see earlier results.
  always_comb begin
    keep   = '0;
    offend = 1'b0;
    off_pc = '0;
    for (int k = 0; k < LANES; k++) begin
      keep[k] = in_valid[k] && !offend;
      if (keep[k] && !in_exc && in_bp_taken[k] && !in_is_branch[k]) begin
        offend = 1'b1;
        off_pc = in_pc + 32'(4 * k + 4);
      end
    end
  end

  logic [LANES-1:0] lane_ds, lane_lk;
  logic             pend_hit, top_br, top_lk, prev_keep, prev_br, prev_lk;
  logic [31:0]      top_pc, lane_pc;

  // NOTE: every output gets a default first, so no path leaves a latch behind.
  always_comb begin
    lane_ds   = '0;
    lane_lk   = '0;
    pend_hit  = 1'b0;
    top_br    = 1'b0;
    top_lk    = 1'b0;
    top_pc    = '0;
    prev_keep = 1'b0;
    prev_br   = 1'b0;
    prev_lk   = 1'b0;
    lane_pc   = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_pc = in_pc + 32'(4 * k);
      if (keep[k]) begin
        if (!in_exc && prev_keep && prev_br) begin
          lane_ds[k] = 1'b1;
          lane_lk[k] = prev_lk;
        end else if (pend_q && lane_pc == pend_pc_q) begin
          lane_ds[k] = 1'b1;
          lane_lk[k] = pend_likely_q;
        end
        if (pend_q && lane_pc == pend_pc_q) pend_hit = 1'b1;
        top_br = in_is_branch[k];
        top_lk = in_is_likely[k];
        top_pc = lane_pc + 32'd4;
      end
      prev_keep = keep[k];
      prev_br   = in_is_branch[k];
      prev_lk   = in_is_likely[k];
    end
  end

  logic [LANES-1:0]    g_valid, g_ds, g_lk;
  logic [32*LANES-1:0] g_pc;

  always_comb begin
    int n;
    n       = 0;
    g_valid = '0;
    g_ds    = '0;
    g_lk    = '0;
    g_pc    = '0;
    for (int k = 0; k < LANES; k++) begin
      if (keep[k]) begin
        for (int j = 0; j < LANES; j++) begin
          if (j == n) begin
            g_valid[j]       = 1'b1;
            g_pc[32*j +: 32] = in_pc + 32'(4 * k);
            g_ds[j]          = lane_ds[k];
            g_lk[j]          = lane_lk[k];
          end
        end
        n++;
      end
    end
  end

  assign in_ready = (count_q < FULL) && !redirect_valid_q;
  assign acc      = in_ready && (|in_valid) && !flush;
  assign push     = acc;
  assign pop      = out_ready && (count_q != '0);

  always_comb begin
    count_d          = count_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    pend_d           = pend_q;
    pend_pc_d        = pend_pc_q;
    pend_likely_d    = pend_likely_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      pend_d   = 1'b0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      if (acc) begin
        if (pend_hit) pend_d = 1'b0;
        if (!in_exc && top_br) begin
          pend_d        = 1'b1;
          pend_pc_d     = top_pc;
          pend_likely_d = top_lk;
        end
        if (offend) begin
          redirect_valid_d = 1'b1;
          redirect_pc_d    = off_pc;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q          <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      pend_q           <= 1'b0;
      pend_pc_q        <= '0;
      pend_likely_q    <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      count_q          <= count_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      pend_q           <= pend_d;
      pend_pc_q        <= pend_pc_d;
      pend_likely_q    <= pend_likely_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  // NOTE: group storage is not reset; count_q gates it, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_valid_q[wr_ptr_q] <= g_valid;
      mem_pc_q[wr_ptr_q]    <= g_pc;
      mem_ds_q[wr_ptr_q]    <= g_ds;
      mem_lk_q[wr_ptr_q]    <= g_lk;
      mem_exc_q[wr_ptr_q]   <= g_valid & {LANES{in_exc}};
    end
  end

  always_comb begin
    out_valid     = '0;
    out_pc        = '0;
    out_in_ds     = '0;
    out_likely_ds = '0;
    out_exc       = '0;
    if (count_q != '0) begin
      out_valid     = mem_valid_q[rd_ptr_q];
      out_pc        = mem_pc_q[rd_ptr_q];
      out_in_ds     = mem_ds_q[rd_ptr_q];
      out_likely_ds = mem_lk_q[rd_ptr_q];
      out_exc       = mem_exc_q[rd_ptr_q];
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_decode_group_queue.sv
// Bench for decode_group_queue: directed scenarios plus a randomized run
// against a queue-of-groups reference model.
module tb_decode_group_queue;

  localparam int LANES = 2;
  localparam int DEPTH = 4;

  logic                clk;
  logic                resetn;
  logic                flush;
  logic [LANES-1:0]    in_valid;
  logic [31:0]         in_pc;
  logic [LANES-1:0]    in_is_branch;
  logic [LANES-1:0]    in_is_likely;
  logic [LANES-1:0]    in_bp_taken;
  logic                in_exc;
  logic                in_ready;
  logic [LANES-1:0]    out_valid;
  logic [32*LANES-1:0] out_pc;
  logic [LANES-1:0]    out_in_ds;
  logic [LANES-1:0]    out_likely_ds;
  logic [LANES-1:0]    out_exc;
  logic                out_ready;
  logic                redirect_valid;
  logic [31:0]         redirect_pc;

  int n_cmp = 0;
  int n_mis = 0;

  decode_group_queue #(.LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_is_branch(in_is_branch),
    .in_is_likely(in_is_likely), .in_bp_taken(in_bp_taken), .in_exc(in_exc),
    .in_ready(in_ready), .out_valid(out_valid), .out_pc(out_pc),
    .out_in_ds(out_in_ds), .out_likely_ds(out_likely_ds), .out_exc(out_exc),
    .out_ready(out_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [LANES-1:0]    v;
    logic [LANES-1:0]    ds;
    logic [LANES-1:0]    lk;
    logic [LANES-1:0]    exc;
    logic [32*LANES-1:0] pc;
  } grp_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] pc, input logic [1:0] br,
                       input logic [1:0] lk, input logic [1:0] bp, input logic exc);
    in_valid     = v;
    in_pc        = pc;
    in_is_branch = br;
    in_is_likely = lk;
    in_bp_taken  = bp;
    in_exc       = exc;
  endtask

  task automatic idle();
    drive(2'b00, 32'h0, 2'b00, 2'b00, 2'b00, 1'b0);
  endtask

  task automatic test_reset();
    resetn = 1'b0; flush = 1'b0; out_ready = 1'b0;
    idle();
    tick(); tick();
    n_cmp++; if (out_valid !== 2'b00) begin n_mis++; $display("FAIL reset_out_valid: got %b want 00", out_valid); end
    n_cmp++; if (redirect_valid !== 1'b0) begin n_mis++; $display("FAIL reset_redirect_valid: got %b want 0", redirect_valid); end
    n_cmp++; if (redirect_pc !== 32'h0) begin n_mis++; $display("FAIL reset_redirect_pc: got %h want 0", redirect_pc); end
    resetn = 1'b1;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_mis++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 2'b00) begin n_mis++; $display("FAIL reset_out_valid_after: got %b want 00", out_valid); end
  endtask

  task automatic test_compaction();
    out_ready = 1'b1;
    drive(2'b10, 32'h100, 2'b00, 2'b00, 2'b00, 1'b0);
    tick();
    n_cmp++; if (out_valid !== 2'b01) begin n_mis++; $display("FAIL compact_valid: got %b want 01", out_valid); end
    n_cmp++; if (out_pc !== 64'h0000_0000_0000_0104) begin n_mis++; $display("FAIL compact_pc: got %h want 104", out_pc); end
    n_cmp++; if (out_in_ds !== 2'b00) begin n_mis++; $display("FAIL compact_ds: got %b want 00", out_in_ds); end
    drive(2'b11, 32'h140, 2'b00, 2'b00, 2'b00, 1'b0);
    tick();
    n_cmp++; if (out_valid !== 2'b11) begin n_mis++; $display("FAIL compact_both_valid: got %b want 11", out_valid); end
    n_cmp++; if (out_pc !== 64'h0000_0144_0000_0140) begin n_mis++; $display("FAIL compact_both_pc: got %h want 144/140", out_pc); end
    idle();
    tick();
    n_cmp++; if (out_valid !== 2'b00) begin n_mis++; $display("FAIL compact_drain: got %b want 00", out_valid); end
  endtask

  task automatic test_delay_slot();
    out_ready = 1'b1;
    drive(2'b11, 32'h200, 2'b01, 2'b01, 2'b00, 1'b0);
    tick();
    n_cmp++; if (out_in_ds !== 2'b10) begin n_mis++; $display("FAIL ds_inpacket: got %b want 10", out_in_ds); end
    n_cmp++; if (out_likely_ds !== 2'b10) begin n_mis++; $display("FAIL ds_inpacket_likely: got %b want 10", out_likely_ds); end
    drive(2'b01, 32'h208, 2'b01, 2'b01, 2'b00, 1'b0);
    tick();
    n_cmp++; if (out_in_ds !== 2'b00) begin n_mis++; $display("FAIL ds_pend_set: got %b want 00", out_in_ds); end
    drive(2'b01, 32'h400, 2'b00, 2'b00, 2'b00, 1'b0);
    tick();
    n_cmp++; if (out_in_ds !== 2'b00) begin n_mis++; $display("FAIL ds_nonmatch: got %b want 00", out_in_ds); end
    drive(2'b11, 32'h208, 2'b00, 2'b00, 2'b00, 1'b0);
    tick();
    n_cmp++; if (out_in_ds !== 2'b10) begin n_mis++; $display("FAIL ds_cross_packet: got %b want 10", out_in_ds); end
    n_cmp++; if (out_likely_ds !== 2'b10) begin n_mis++; $display("FAIL ds_cross_likely: got %b want 10", out_likely_ds); end
    drive(2'b11, 32'h208, 2'b00, 2'b00, 2'b00, 1'b0);
    tick();
    n_cmp++; if (out_in_ds !== 2'b00) begin n_mis++; $display("FAIL ds_pend_consumed: got %b want 00", out_in_ds); end
    idle();
    tick();
  endtask

  task automatic test_false_predict();
    out_ready = 1'b1;
    drive(2'b11, 32'h300, 2'b00, 2'b00, 2'b01, 1'b0);
    tick();
    n_cmp++; if (out_valid !== 2'b01) begin n_mis++; $display("FAIL fp_kept: got %b want 01", out_valid); end
    n_cmp++; if (out_pc[31:0] !== 32'h300) begin n_mis++; $display("FAIL fp_pc: got %h want 300", out_pc[31:0]); end
    n_cmp++; if (redirect_valid !== 1'b1) begin n_mis++; $display("FAIL fp_redirect: got %b want 1", redirect_valid); end
    n_cmp++; if (redirect_pc !== 32'h304) begin n_mis++; $display("FAIL fp_redirect_pc: got %h want 304", redirect_pc); end
    n_cmp++; if (in_ready !== 1'b0) begin n_mis++; $display("FAIL fp_in_ready: got %b want 0", in_ready); end
    drive(2'b11, 32'h308, 2'b00, 2'b00, 2'b00, 1'b0);
    tick();
    idle();
    n_cmp++; if (redirect_valid !== 1'b0) begin n_mis++; $display("FAIL fp_pulse_end: got %b want 0", redirect_valid); end
    n_cmp++; if (out_valid !== 2'b00) begin n_mis++; $display("FAIL fp_wrong_path_dropped: got %b want 00", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_mis++; $display("FAIL fp_ready_back: got %b want 1", in_ready); end
  endtask

  task automatic test_exception();
    out_ready = 1'b1;
    drive(2'b01, 32'h500, 2'b01, 2'b01, 2'b00, 1'b0);
    tick();
    drive(2'b11, 32'h600, 2'b10, 2'b00, 2'b01, 1'b1);
    tick();
    n_cmp++; if (out_valid !== 2'b11) begin n_mis++; $display("FAIL exc_no_squash: got %b want 11", out_valid); end
    n_cmp++; if (out_exc !== 2'b11) begin n_mis++; $display("FAIL exc_flag: got %b want 11", out_exc); end
    n_cmp++; if (out_in_ds !== 2'b00) begin n_mis++; $display("FAIL exc_no_ds: got %b want 00", out_in_ds); end
    n_cmp++; if (redirect_valid !== 1'b0) begin n_mis++; $display("FAIL exc_no_redirect: got %b want 0", redirect_valid); end
    drive(2'b01, 32'h504, 2'b00, 2'b00, 2'b00, 1'b0);
    tick();
    n_cmp++; if (out_in_ds !== 2'b01) begin n_mis++; $display("FAIL exc_pend_kept: got %b want 01", out_in_ds); end
    n_cmp++; if (out_likely_ds !== 2'b01) begin n_mis++; $display("FAIL exc_pend_likely: got %b want 01", out_likely_ds); end
    n_cmp++; if (out_exc !== 2'b00) begin n_mis++; $display("FAIL exc_cleared: got %b want 00", out_exc); end
    drive(2'b01, 32'h608, 2'b00, 2'b00, 2'b00, 1'b0);
    tick();
    n_cmp++; if (out_in_ds !== 2'b00) begin n_mis++; $display("FAIL exc_no_new_pend: got %b want 00", out_in_ds); end
    idle();
    tick();
  endtask

  task automatic test_fill_drain();
    logic [31:0] base;
    for (int r = 0; r < 3; r++) begin
      base = 32'h1000 + 32'(r * 32'h100);
      out_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        drive(2'b11, base + 32'(16 * i), 2'b00, 2'b00, 2'b00, 1'b0);
        tick();
      end
      n_cmp++; if (in_ready !== 1'b0) begin n_mis++; $display("FAIL fill_full_ready r%0d: got %b want 0", r, in_ready); end
      drive(2'b11, 32'hDEA0, 2'b00, 2'b00, 2'b00, 1'b0);
      out_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        n_cmp++;
        if (out_pc !== {base + 32'(16 * i + 4), base + 32'(16 * i)} || out_valid !== 2'b11) begin
          n_mis++; $display("FAIL drain_order r%0d i%0d: got %b/%h want 11/%h", r, i, out_valid, out_pc, base + 32'(16 * i));
        end
        tick();
        idle();
        n_cmp++; if (in_ready !== 1'b1) begin n_mis++; $display("FAIL drain_ready r%0d i%0d: got %b want 1", r, i, in_ready); end
      end
      n_cmp++; if (out_valid !== 2'b00) begin n_mis++; $display("FAIL drain_empty r%0d: got %b want 00", r, out_valid); end
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(2'b11, 32'hA00, 2'b00, 2'b00, 2'b00, 1'b0); tick();
    drive(2'b11, 32'hA10, 2'b00, 2'b00, 2'b00, 1'b0); tick();
    drive(2'b01, 32'hA20, 2'b01, 2'b00, 2'b00, 1'b0); tick();
    flush = 1'b1;
    drive(2'b11, 32'hB00, 2'b00, 2'b00, 2'b00, 1'b0);
    tick();
    flush = 1'b0;
    idle();
    n_cmp++; if (out_valid !== 2'b00) begin n_mis++; $display("FAIL flush_empty: got %b want 00", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_mis++; $display("FAIL flush_ready: got %b want 1", in_ready); end
    out_ready = 1'b1;
    drive(2'b01, 32'hA24, 2'b00, 2'b00, 2'b00, 1'b0);
    tick();
    idle();
    n_cmp++; if (out_pc[31:0] !== 32'hA24) begin n_mis++; $display("FAIL flush_repush_pc: got %h want a24", out_pc[31:0]); end
    n_cmp++; if (out_in_ds !== 2'b00) begin n_mis++; $display("FAIL flush_pend_cleared: got %b want 00", out_in_ds); end
    tick();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(2'b11, 32'hC00, 2'b00, 2'b00, 2'b00, 1'b0);
    tick();
    idle();
    n_cmp++; if (out_valid !== 2'b11) begin n_mis++; $display("FAIL areset_pre: got %b want 11", out_valid); end
    #2 resetn = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 2'b00) begin n_mis++; $display("FAIL areset_async_drop: got %b want 00", out_valid); end
    @(negedge clk);
    resetn = 1'b1;
    tick();
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 2'b00) begin n_mis++; $display("FAIL areset_after: got %b/%b want 1/00", in_ready, out_valid); end
  endtask

  task automatic test_random();
    grp_t        mq[$];
    grp_t        g, g0, exp_g;
    bit          m_pend, m_pend_lk, m_rv, off, hit, acc, pop, exp_ready;
    logic [31:0] m_pend_pc, m_rpc, off_pc, pc_k, last_pc;
    int          kept[$];
    int          k, last;

    resetn = 1'b0; flush = 1'b0; out_ready = 1'b0;
    idle();
    tick();
    resetn = 1'b1;
    tick();
    mq.delete();
    m_pend = 0; m_pend_lk = 0; m_pend_pc = '0; m_rv = 0; m_rpc = '0; last_pc = 32'h2000;

    for (int cyc = 0; cyc < 800; cyc++) begin
      in_valid = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       in_pc = last_pc + 32'd8;
        1:       in_pc = m_pend ? m_pend_pc - 32'(4 * $urandom_range(0, 1)) : last_pc;
        default: in_pc = 32'($urandom_range(0, 1023)) << 2;
      endcase
      last_pc = in_pc;
      for (int b = 0; b < LANES; b++) begin
        in_is_branch[b] = ($urandom_range(0, 3) == 0);
        in_is_likely[b] = $urandom_range(0, 1) == 1;
        in_bp_taken[b]  = ($urandom_range(0, 5) == 0);
      end
      in_exc    = ($urandom_range(0, 9) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      out_ready = $urandom_range(0, 1) == 1;

      exp_ready = (mq.size() < DEPTH) && !m_rv;
      n_cmp++; if (in_ready !== exp_ready) begin n_mis++; $display("FAIL rnd_in_ready c%0d: got %b want %b", cyc, in_ready, exp_ready); end
      acc = exp_ready && (in_valid != 0) && !flush;
      pop = out_ready && mq.size() > 0;

      kept.delete(); off = 0; off_pc = '0;
      for (int i = 0; i < LANES; i++) begin
        if (in_valid[i] && !off) begin
          kept.push_back(i);
          if (!in_exc && in_bp_taken[i] && !in_is_branch[i]) begin off = 1; off_pc = in_pc + 32'(4 * i + 4); end
        end
      end
      g = '0; hit = 0;
      for (int j = 0; j < kept.size(); j++) begin
        k = kept[j];
        pc_k = in_pc + 32'(4 * k);
        g.v[j] = 1'b1;
        g.pc[32*j +: 32] = pc_k;
        g.exc[j] = in_exc;
        if (m_pend && pc_k == m_pend_pc) hit = 1;
        if (!in_exc && j > 0 && kept[j-1] == k - 1 && in_is_branch[k-1]) begin
          g.ds[j] = 1'b1; g.lk[j] = in_is_likely[k-1];
        end else if (m_pend && pc_k == m_pend_pc) begin
          g.ds[j] = 1'b1; g.lk[j] = m_pend_lk;
        end
      end

      tick();

      if (pop) g0 = mq.pop_front();
      if (flush) begin
        mq.delete(); m_pend = 0; m_rv = 0;
      end else begin
        m_rv = acc && off;
        if (acc && off) m_rpc = off_pc;
        if (acc) begin
          mq.push_back(g);
          if (hit) m_pend = 0;
          last = kept[kept.size()-1];
          if (!in_exc && in_is_branch[last]) begin
            m_pend = 1; m_pend_pc = in_pc + 32'(4 * last + 4); m_pend_lk = in_is_likely[last];
          end
        end
      end
      exp_g = (mq.size() > 0) ? mq[0] : '0;

      n_cmp++; if (out_valid !== exp_g.v) begin n_mis++; $display("FAIL rnd_out_valid c%0d: got %b want %b", cyc, out_valid, exp_g.v); end
      n_cmp++; if (out_pc !== exp_g.pc) begin n_mis++; $display("FAIL rnd_out_pc c%0d: got %h want %h", cyc, out_pc, exp_g.pc); end
      n_cmp++; if (out_in_ds !== exp_g.ds) begin n_mis++; $display("FAIL rnd_in_ds c%0d: got %b want %b", cyc, out_in_ds, exp_g.ds); end
      n_cmp++; if (out_likely_ds !== exp_g.lk) begin n_mis++; $display("FAIL rnd_likely_ds c%0d: got %b want %b", cyc, out_likely_ds, exp_g.lk); end
      n_cmp++; if (out_exc !== exp_g.exc) begin n_mis++; $display("FAIL rnd_exc c%0d: got %b want %b", cyc, out_exc, exp_g.exc); end
      n_cmp++; if (redirect_valid !== m_rv) begin n_mis++; $display("FAIL rnd_redirect_valid c%0d: got %b want %b", cyc, redirect_valid, m_rv); end
      n_cmp++; if (redirect_pc !== m_rpc) begin n_mis++; $display("FAIL rnd_redirect_pc c%0d: got %h want %h", cyc, redirect_pc, m_rpc); end
    end
    flush = 1'b0;
    idle();
  endtask

  initial begin
    test_reset();
    test_compaction();
    test_delay_slot();
    test_false_predict();
    test_exception();
    test_fill_drain();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
